// File: rtl/neuron_pkg.sv
// Shared constants and arithmetic helpers for the fixed-point neuron datapath.
package neuron_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_FRAC_W = 8;
    localparam int unsigned DEF_ACC_W  = 40;

    // Wide working width so one helper serves any legal parameter set.
    localparam int unsigned RS_W = 128;
    localparam int unsigned RV_W = 64;

    typedef struct packed {
        logic                   sat;
        logic signed [RV_W-1:0] val;
    } round_sat_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Round half up at frac_w, then clamp to a data_w-bit signed range.
    function automatic round_sat_t round_sat(input logic signed [RS_W-1:0] t,
                                             input int unsigned frac_w,
                                             input int unsigned data_w);
        logic signed [RS_W-1:0] rnd;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        round_sat_t             o;
        rnd   = 128'sd1 <<< (frac_w - 1);
        r     = (t + rnd) >>> frac_w;
        hi    = (128'sd1 <<< (data_w - 1)) - 128'sd1;
        lo    = -(128'sd1 <<< (data_w - 1));
        o.sat = 1'b0;
        o.val = r[RV_W-1:0];
        if (r > hi) begin
            o.val = hi[RV_W-1:0];
            o.sat = 1'b1;
        end else if (r < lo) begin
            o.val = lo[RV_W-1:0];
            o.sat = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Registered binary adder tree over LANES W-bit inputs; one-cycle latency.
module lane_adder_tree #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES*W-1:0] i_lanes,
    output logic [W-1:0]       o_sum
);

    // Heap layout: leaves at LANES..2*LANES-1, node k sums 2k and 2k+1, root at 1.
    logic [W-1:0] w_node [1:2*LANES-1];

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            w_node[LANES+i] = i_lanes[i*W +: W];
        end
        for (int unsigned k = LANES - 1; k >= 1; k--) begin
            w_node[k] = w_node[2*k] + w_node[2*k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) o_sum <= '0;
        else     o_sum <= w_node[1];
    end

endmodule

// File: rtl/neuron_mac.sv
// Multi-lane fixed-point MAC neuron with bias, rounding and saturation.
// Optional macro NEURON_MAC_RELU_EN forces negative results to zero.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FRAC_W    = DEF_FRAC_W,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned MAX_BEATS = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   x,
    input  logic [LANES*DATA_W-1:0]   weight,
    input  logic                      x_valid,
    input  logic                      w_valid,
    input  logic                      x_last,
    input  logic [DATA_W-1:0]         bias,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    output logic                      result_sat,
    output logic [clog2(MAX_BEATS):0] result_beats,
    output logic                      pair_err
);

    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned CNT_W = clog2(MAX_BEATS) + 1;

    logic                    w_accept;
    logic                    r_in_first;
    logic [LANES*PW-1:0]     r_prod;
    logic                    r_s1_valid, r_s1_last, r_s1_first;
    logic [DATA_W-1:0]       r_s1_bias;
    logic                    r_s2_valid, r_s2_last, r_s2_first;
    logic [DATA_W-1:0]       r_s2_bias;
    logic [LANES*ACC_W-1:0]  w_tree_in;
    logic [ACC_W-1:0]        w_tree_sum;
    logic [ACC_W-1:0]        r_acc, w_acc_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic signed [RS_W-1:0]  w_t;
    round_sat_t              w_rs;
    logic [DATA_W-1:0]       w_res;
    logic [RV_W-DATA_W-1:0]  w_unused_hi;
    logic [DATA_W-1:0]       r_result;
    logic                    r_result_valid, r_result_sat, r_pair_err;
    logic [CNT_W-1:0]        r_result_beats;

    assign w_accept = x_valid && w_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_first <= 1'b1;
            r_prod     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_bias  <= '0;
            r_pair_err <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_pair_err <= r_pair_err | (x_valid ^ w_valid);
            if (w_accept) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_prod[i*PW +: PW] <= PW'($signed(x[i*DATA_W +: DATA_W]))
                                        * PW'($signed(weight[i*DATA_W +: DATA_W]));
                end
                r_s1_last  <= x_last;
                r_s1_first <= r_in_first;
                r_s1_bias  <= bias;
                r_in_first <= x_last;
            end
        end
    end

    always_comb begin
        w_tree_in = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_tree_in[i*ACC_W +: ACC_W] = ACC_W'($signed(r_prod[i*PW +: PW]));
        end
    end

    lane_adder_tree #(.LANES(LANES), .W(ACC_W)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_lanes (w_tree_in),
        .o_sum   (w_tree_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_bias  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_first <= r_s1_first;
            r_s2_bias  <= r_s1_bias;
        end
    end

    always_comb begin
        w_acc_next  = (r_s2_first ? '0 : r_acc) + w_tree_sum;
        w_cnt_next  = r_s2_first ? CNT_W'(1)
                    : (r_cnt >= CNT_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : r_cnt + CNT_W'(1);
        w_t         = RS_W'($signed(w_acc_next)) + (RS_W'($signed(r_s2_bias)) <<< FRAC_W);
        w_rs        = round_sat(w_t, FRAC_W, DATA_W);
        w_res       = w_rs.val[DATA_W-1:0];
        w_unused_hi = w_rs.val[RV_W-1:DATA_W];
`ifdef NEURON_MAC_RELU_EN
        if (w_res[DATA_W-1]) w_res = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_sat   <= 1'b0;
            r_result_beats <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (r_s2_valid) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (r_s2_last) begin
                    r_result       <= w_res;
                    r_result_sat   <= w_rs.sat;
                    r_result_beats <= w_cnt_next;
                    r_result_valid <= 1'b1;
                end
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_sat   = r_result_sat;
    assign result_beats = r_result_beats;
    assign pair_err     = r_pair_err;

endmodule
